sreg_deser: RTL
===============

SREG_DESER -- requirements
Module: sreg_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 16, word length in bits (2..32).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port sin  input  1  serial data bit, sampled only when sft=1.
REQ-005 SHALL have port sft  input  1  bit strobe; one bit accepted per cycle with sft=1.
REQ-006 SHALL have port clr  input  1  synchronous frame resync; discards the partial word.
REQ-007 SHALL have port pout  output  WIDTH  assembled word holding register.
REQ-008 SHALL have port pvalid  output  1  pout holds an unconsumed word.
REQ-009 SHALL have port pready  input  1  consumer accepts pout; transfer when pvalid=1 and pready=1.
REQ-010 SHALL have port busy  output  1  partial word in progress (bit count nonzero).
REQ-011 SHALL have port ovf  output  1  sticky overrun flag.
REQ-012 SHALL have port perr  output  1  parity error for the word in pout.

Function
REQ-013 SHALL shift left, MSB first: on sft=1, sr <= {sr[WIDTH-2:0], sin}; bit count increments.
REQ-014 SHALL hold sr and count unchanged when sft=0 and clr=0.
REQ-015 SHALL complete a word on the sft=1 cycle carrying the final frame bit; count wraps to 0 at that edge.
REQ-016 SHALL on completion load pout with the WIDTH data bits (final data bit included) at the same edge; pvalid=1 from the next cycle (latency 1 cycle after final sft).
REQ-017 SHALL clear pvalid on the edge where pvalid=1 and pready=1, unless a word completes on that edge.
REQ-018 SHALL, when completion coincides with pvalid=1 and pready=1, load the new word, keep pvalid=1, leave ovf unchanged.
REQ-019 SHALL, when completion occurs with pvalid=1 and pready=0, drop the new word, keep pout/perr unchanged, set ovf=1.
REQ-020 SHALL keep ovf set until clr=1 or reset.
REQ-021 SHALL on clr=1 zero sr, count and ovf; clr overrides sft in the same cycle; pout, pvalid and perr are unaffected.
REQ-022 SHALL drive busy = (count != 0), registered state, no combinational path from sft.
REQ-023 SHALL ignore pready while pvalid=0.

Reset
REQ-024 SHALL on reset_n=0 immediately force sr=0, count=0, pout=0, pvalid=0, ovf=0, perr=0, busy=0.
REQ-025 SHALL discard any partial word on reset mid-frame; first post-reset sft bit is the new word's MSB.
REQ-026 SHALL ignore all inputs while reset_n=0 and resume on the first rising clk after release.

Configuration
REQ-027 SHALL, with SREG_DESER_PARITY_EN defined, use a WIDTH+1 bit frame: WIDTH data bits then one even-parity bit, not shifted into sr.
REQ-028 SHALL, with SREG_DESER_PARITY_EN defined, load perr with (XOR of data bits) XOR parity bit at completion; overrun-dropped words do not update perr.
REQ-029 SHALL, without SREG_DESER_PARITY_EN, use a WIDTH-bit frame, tie perr to 0, and contain no parity logic.

Verification (WIDTH=16)
REQ-030 SHALL verify: 16 sft bits of 0xA5C3 MSB first, pready=0 -> pout=0xA5C3, pvalid=1 exactly one cycle after 16th sft, busy=0, ovf=0.
REQ-031 SHALL verify: 0x1111 then 0x2222 with pready=0 -> pout=0x1111, ovf=1; pready=1 one cycle -> pvalid=0; clr -> ovf=0.
REQ-032 SHALL verify: pvalid=1 (0x00FF), pready=1 on final sft cycle of 0xFF00 -> pout=0xFF00, pvalid stays 1, ovf=0.
REQ-033 SHALL verify: 5 bits, clr with sft=1 same cycle, then 16 bits of 0x1234 -> pout=0x1234; 5 bits, reset_n pulse, then 0xBEEF -> pout=0xBEEF.
REQ-034 SHALL verify with SREG_DESER_PARITY_EN: 0x0003 + parity 0 -> perr=0; 0x0007 + parity 0 -> perr=1; pvalid after 17th sft.

Source files
------------

// File: rtl/sreg_deser.sv
//------------------------------------------------------------------------------
// Module      : sreg_deser
// Description : Serial-in / parallel-out deserializer. Bits arrive MSB first
//               on sin, one per cycle with sft=1. A completed word is moved
//               into a holding register (pout) and offered to a consumer with
//               a valid/ready handshake. If the holder is still full when a
//               new word completes, the new word is dropped and a sticky
//               overrun flag is raised.
// Build option: SREG_DESER_PARITY_EN
//               Defined   : frame is WIDTH data bits plus one even-parity bit.
//                           perr reports the parity check of the held word.
//               Undefined : frame is WIDTH data bits, perr is tied to 0.
// Ports       : clk      - system clock, rising edge
//               reset_n  - asynchronous active-low reset
//               sin      - serial data bit (sampled when sft=1)
//               sft      - bit strobe
//               clr      - synchronous resync: drops partial word, clears ovf
//               pout     - assembled word holding register
//               pvalid   - pout holds an unconsumed word
//               pready   - consumer accepts pout
//               busy     - partial word in progress
//               ovf      - sticky overrun flag
//               perr     - parity error of the word in pout
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sreg_deser #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sin,
  input  logic             sft,
  input  logic             clr,
  output logic [WIDTH-1:0] pout,
  output logic             pvalid,
  input  logic             pready,
  output logic             busy,
  output logic             ovf,
  output logic             perr
);

`ifdef SREG_DESER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  // Counter only needs to reach FRAME_LEN-1; it wraps to 0 on completion.
  localparam int            CW       = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  logic [WIDTH-1:0] sr_q,     sr_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] pout_q,   pout_d;
  logic             pvalid_q, pvalid_d;
  logic             ovf_q,    ovf_d;

  logic             w_last;
  logic             w_done;
  logic [WIDTH-1:0] w_word;

  // Final frame bit arriving on this edge (clr suppresses completion).
  assign w_last = sft && (cnt_q == LAST_CNT);
  assign w_done = w_last && !clr;

`ifdef SREG_DESER_PARITY_EN
  logic perr_q, perr_d;

  // The final bit is the parity bit, so sr already holds every data bit.
  assign w_word = sr_q;
`else
  logic w_unused_sr_msb;

  // The final bit is the word's LSB; take it straight from sin so the word
  // is available on the completing edge. The old MSB falls off the end.
  assign w_word          = {sr_q[WIDTH-2:0], sin};
  assign w_unused_sr_msb = sr_q[WIDTH-1];
`endif

  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    pout_d   = pout_q;
    pvalid_d = pvalid_q;
    ovf_d    = ovf_q;
`ifdef SREG_DESER_PARITY_EN
    perr_d   = perr_q;
`endif

    // Shift register / bit counter. clr wins over sft.
    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (sft) begin
      if (w_last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
`ifdef SREG_DESER_PARITY_EN
      // Parity bit is checked, never stored in sr.
      if (!w_last) begin
        sr_d = {sr_q[WIDTH-2:0], sin};
      end
`else
      sr_d = {sr_q[WIDTH-2:0], sin};
`endif
    end

    // Holding register handshake. A completion while the holder is free,
    // or being drained on this very edge, replaces its contents; otherwise
    // the new word is lost and the overrun is recorded.
    if (w_done) begin
      if (!pvalid_q || pready) begin
        pout_d   = w_word;
        pvalid_d = 1'b1;
`ifdef SREG_DESER_PARITY_EN
        perr_d   = (^sr_q) ^ sin;
`endif
      end else begin
        ovf_d = 1'b1;
      end
    end else if (pvalid_q && pready) begin
      pvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      pout_q   <= '0;
      pvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SREG_DESER_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      pout_q   <= pout_d;
      pvalid_q <= pvalid_d;
      ovf_q    <= ovf_d;
`ifdef SREG_DESER_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  assign pout   = pout_q;
  assign pvalid = pvalid_q;
  assign ovf    = ovf_q;
  assign busy   = (cnt_q != '0);
`ifdef SREG_DESER_PARITY_EN
  assign perr   = perr_q;
`else
  assign perr   = 1'b0;
`endif

endmodule

`default_nettype wire
